// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine feeding the HI/LO write port; mul 2 cycles, div DATA_WIDTH+1, div-by-zero 2.
// No queueing: start is taken only in IDLE or DONE, busy stalls the pipeline, cancel aborts an in-flight op.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic                  is_signed, a_neg, q_neg;
  logic [W-1:0]          b_mag, rem_nxt, quo_nxt;
  logic [W:0]            trial;
  logic signed [2*W-1:0] prod_s;
  logic [2*W-1:0]        prod_u, prod;

  // op[0]=0 selects the signed variants for both multiply and divide
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[W-1];
  assign q_neg     = a_neg ^ (is_signed & b_q[W-1]);
  assign b_mag     = (is_signed && b_q[W-1]) ? -b_q : b_q;

  // Dividend magnitude sits in quo_q and shifts out MSB-first into the remainder
  assign trial   = {rem_q, quo_q[W-1]} - {1'b0, b_mag};
  assign rem_nxt = trial[W] ? {rem_q[W-2:0], quo_q[W-1]} : trial[W-1:0];
  assign quo_nxt = {quo_q[W-2:0], ~trial[W]};

  assign prod_s = $signed(a_q) * $signed(b_q);
  assign prod_u = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
  assign prod   = op_q[0] ? prod_u : prod_s;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !cancel) begin
          state_d = op[1] ? S_DIV : S_MUL;
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
          rem_d   = '0;
          quo_d   = (!op[0] && src_a[W-1]) ? -src_a : src_a;
          cnt_d   = '0;
        end
      end
      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          hi_d    = prod[2*W-1:W];
          lo_d    = prod[W-1:0];
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (b_q == '0) begin
          state_d = S_DONE;
          hi_d    = a_q;
          lo_d    = '1;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W-1)) begin
            state_d = S_DONE;
            hi_d    = a_neg ? -rem_nxt : rem_nxt;
            lo_d    = q_neg ? -quo_nxt : quo_nxt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
  assign write_en = (state_q == S_DONE);
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide engine for MULT, MULTU, DIV and DIVU; the producer side of the HI/LO register pair.
- Sits in the execute stage and drives the HI/LO write port (write_en, hi, lo) with a single-cycle write pulse when a result is ready.
- Exposes busy so the pipeline controller stalls dependent MFHI/MFLO reads and any new mul/div issue.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; product is 2*DATA_WIDTH; divider iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  issue request; operands and op are sampled when start=1 and the unit is idle or in DONE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- src_a  input  DATA_WIDTH  multiplicand / dividend
- src_b  input  DATA_WIDTH  multiplier / divisor
- cancel  input  1  exception flush; aborts an in-flight operation
- busy  output  1  high in MUL and DIV states
- write_en  output  1  one-cycle HI/LO write strobe, high only in DONE
- hi_o  output  DATA_WIDTH  product[63:32] or remainder
- lo_o  output  DATA_WIDTH  product[31:0] or quotient

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, write_en=0, hi_o=0, lo_o=0, all internal registers cleared. Applies immediately, including mid-operation, with no write.
- States:
  - IDLE: accepts start and goes to MUL (op[1]=0) or DIV (op[1]=1).
  - MUL: one cycle, registers the full 64-bit product, then goes to DONE.
  - DIV: runs the iteration sequence, then goes to DONE.
  - DONE: write_en=1 for exactly one cycle. Goes to IDLE, or directly to MUL/DIV if start=1 in the same cycle (back-to-back issue).
- Operands and op are latched on acceptance. Input changes afterwards are ignored.
- start while busy=1 is ignored; no queueing.
- Multiply latency: start accepted at edge N, write_en high in cycle N+2.
  - MULT: signed 32x32->64 two's complement.
  - MULTU: unsigned.
- Divide:
  - Restoring radix-2 on magnitudes, one quotient bit per cycle, DATA_WIDTH iterations.
  - Latency: start at edge N, write_en high in cycle N+DATA_WIDTH+1 (N+33 by default).
  - DIV sign rules: quotient truncates toward zero and is negated when operand signs differ; remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0.
- Divide by zero (src_b=0): skips the iterations. DIV takes one cycle, then DONE, so write_en is high in cycle N+2 with hi=src_a and lo=all ones. The same rule applies to signed and unsigned.
- hi_o/lo_o update only on entry to DONE and hold their value afterwards until the next completion or reset.
- cancel:
  - In MUL or DIV: next state is IDLE, no write_en, hi_o/lo_o unchanged.
  - In IDLE: the same-cycle start is dropped.
  - In DONE: no effect; the write still occurs.
- cancel and start together in DONE: the completing write occurs and the new start is dropped.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge 0 -> busy=1 in cycle 1; write_en=1 only in cycle 2 with hi_o=0xFFFFFFFE, lo_o=0x00000001.
- MULT -3 (0xFFFFFFFD) x 5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1; then start DIVU 100/7 in the DONE cycle -> accepted back-to-back; 33 cycles later write_en=1 with lo_o=0x0000000E, hi_o=0x00000002.
- DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0x00000000. DIV 7/-2 -> lo_o=0xFFFFFFFD, hi_o=0x00000001.
- DIVU 5/0 -> write_en in cycle 2 with hi_o=0x00000005, lo_o=0xFFFFFFFF. DIV 0x80000000/0 -> hi_o=0x80000000, lo_o=0xFFFFFFFF.
- Issue DIV, pulse cancel in cycle 10 -> busy=0 from cycle 11, no write_en ever, hi_o/lo_o keep their prior values. A second start during busy (cycle 5) is ignored: only one write occurs.
- Drive rst=0 asynchronously mid-DIV (between edges) -> busy, write_en, hi_o, lo_o all 0 immediately. After release, MULTU 2x3 gives lo_o=6, hi_o=0 with normal latency.
